// File: rtl/condition_handler.sv
// Branch condition evaluation, condition-code register and delay-slot/annul FSM.
// Optional macro CC_FORWARD_EN forwards same-cycle Flags into condition evaluation.
module condition_handler (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Flags,
  input  logic       S,
  input  logic [3:0] Cond,
  input  logic       B_instr,
  input  logic       A,
  input  logic       Stall,
  output logic [3:0] CC,
  output logic       Taken,
  output logic       Annul,
  output logic       DelaySlot
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] DELAY = 2'b01;
  localparam logic [1:0] ANNUL = 2'b10;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       in_annul;
  logic [3:0] ec;
  logic       z, n, c, v;
  logic       cond_true;
  logic       annul_next;
  logic       cc_we;

  assign in_annul = (state == ANNUL);

`ifdef CC_FORWARD_EN
  // Bypass the ALU result of the current instruction, unless it is being annulled.
  assign ec = (S && !in_annul) ? Flags : CC;
`else
  assign ec = CC;
`endif

  assign {z, n, c, v} = ec;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cond_true = 1'b0;
    case (Cond)
      4'h0: cond_true = 1'b0;
      4'h1: cond_true = z;
      4'h2: cond_true = z | (n ^ v);
      4'h3: cond_true = n ^ v;
      4'h4: cond_true = c | z;
      4'h5: cond_true = c;
      4'h6: cond_true = n;
      4'h7: cond_true = v;
      4'h8: cond_true = 1'b1;
      4'h9: cond_true = ~z;
      4'hA: cond_true = ~(z | (n ^ v));
      4'hB: cond_true = ~(n ^ v);
      4'hC: cond_true = ~(c | z);
      4'hD: cond_true = ~c;
      4'hE: cond_true = ~n;
      4'hF: cond_true = ~v;
      default: cond_true = 1'b0;
    endcase
  end

  // A branch sitting in an annulled slot is ignored entirely.
  assign Taken = B_instr & cond_true & ~in_annul;

  // Annul the slot for an untaken annulling branch, or for branch-always with A set.
  assign annul_next = A & (~cond_true | (Cond == 4'h8));

  always_comb begin
    state_next = state;
    if (!Stall) begin
      case (state)
        IDLE, DELAY: begin
          if (B_instr) state_next = annul_next ? ANNUL : DELAY;
          else         state_next = IDLE;
        end
        ANNUL:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign cc_we = S & ~Stall & ~in_annul;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      CC    <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (cc_we) CC <= Flags;
    end
  end

  assign Annul     = in_annul;
  assign DelaySlot = (state == DELAY) || in_annul;

endmodule

// File: doc/condition_handler.md
CONDITION_HANDLER -- requirements
Module: condition_handler

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Flags  input  4  ALU flags {Z,N,C,V}, bit 3 = Z down to bit 0 = V.
REQ-005 S  input  1  condition-code write enable for the current instruction.
REQ-006 Cond  input  4  branch condition field of the current instruction.
REQ-007 B_instr  input  1  current instruction is a conditional branch.
REQ-008 A  input  1  annul bit of the current branch.
REQ-009 Stall  input  1  pipeline hold; freezes all state.
REQ-010 CC  output  4  registered condition codes {Z,N,C,V}.
REQ-011 Taken  output  1  branch taken, combinational.
REQ-012 Annul  output  1  squash the instruction in the delay slot this cycle.
REQ-013 DelaySlot  output  1  the current instruction occupies a delay slot.

Function
REQ-014 On a clk edge with S=1 and Stall=0, CC SHALL load Flags; otherwise CC SHALL hold.
REQ-015 Condition evaluation SHALL use the effective codes Ec (see REQ-030/031) as follows. 0 never. 1 Z. 2 Z|(N^V). 3 N^V. 4 C|Z. 5 C. 6 N. 7 V. 8 always. 9 ~Z. A ~(Z|(N^V)). B ~(N^V). C ~(C|Z). D ~C. E ~N. F ~V.
REQ-016 Taken SHALL equal B_instr & cond_true & (state != ANNUL), with zero cycles of latency.
REQ-017 The FSM SHALL have three states: IDLE, DELAY and ANNUL; Annul=1 only in ANNUL; DelaySlot=1 in DELAY or ANNUL.
REQ-018 From IDLE or DELAY, with B_instr=1 and Stall=0, the next state SHALL be ANNUL if (A=1 and not taken) or (A=1 and Cond=8); otherwise the next state SHALL be DELAY.
REQ-019 From IDLE or DELAY, with B_instr=0 and Stall=0, the next state SHALL be IDLE.
REQ-020 From ANNUL, with Stall=0, the next state SHALL be IDLE regardless of B_instr, because an annulled branch is ignored.
REQ-021 In ANNUL, a CC write SHALL be suppressed even when S=1, because the annulled instruction must not modify state.
REQ-022 With Stall=1, state and CC SHALL hold, and the outputs SHALL reflect the held state.
REQ-023 A branch in a DELAY slot (DCTI couple) SHALL be evaluated normally, and its outcome SHALL select the next state per REQ-018.
REQ-024 With Cond=0 and A=1, the next state SHALL be ANNUL; with Cond=0 and A=0, the next state SHALL be DELAY.

Reset
REQ-025 While reset=1, state SHALL be IDLE and CC SHALL be 4'b0000, asynchronously.
REQ-026 After reset, Taken, Annul and DelaySlot SHALL be 0 until B_instr=1 is presented.
REQ-027 A reset asserted while in DELAY or ANNUL SHALL abort the slot; the first post-reset instruction SHALL NOT be annulled.
REQ-028 A reset SHALL override Stall.
REQ-029 A reset SHALL take priority over a simultaneous S=1 write.

Configuration
REQ-030 With macro CC_FORWARD_EN defined, Ec SHALL be Flags when S=1 (and state != ANNUL), and CC otherwise; this bypasses same-cycle ALU results.
REQ-031 With CC_FORWARD_EN undefined, Ec SHALL always be CC; a branch then sees only codes written on earlier cycles.

Verification
REQ-032 Reset with S=1 and Flags=4'hF -> CC=0, Annul=0, DelaySlot=0; release reset, next edge -> CC=4'hF.
REQ-033 CC=4'b1000, B_instr=1, Cond=1, A=1 -> Taken=1; next cycle DelaySlot=1 and Annul=0.
REQ-034 CC=4'b0000, Cond=1, A=1 -> Taken=0; next cycle Annul=1; a branch Cond=8 in that slot -> Taken=0, and the state returns to IDLE.
REQ-035 Cond=8, A=1 -> Taken=1 and the next cycle has Annul=1; with Stall=1 held for 3 cycles -> Annul stays 1 and CC is unchanged.
REQ-036 CC=0; same cycle S=1, Flags=4'b0100, B_instr=1, Cond=6 -> Taken=1 with CC_FORWARD_EN defined, and Taken=0 without it.
REQ-037 A sweep of all 16 Cond values × 16 CC values -> Taken matches the REQ-015 table.
